// File: rtl/qdiv_sequencer_if.sv
// Job intake, result return and divider-side signals of the Q15.16 divide job sequencer.
interface qdiv_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_dividend;
  logic [31:0] in_divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_quotient;
  logic        out_dz;
  logic        err_timeout;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [31:0] div_quotient;
  logic        div_valid;
  logic        div_busy;

  modport slave (
    input  in_valid, in_dividend, in_divisor, out_ready, div_quotient, div_valid, div_busy,
    output in_ready, out_valid, out_quotient, out_dz, err_timeout, div_dividend, div_divisor
  );

  modport master (
    output in_valid, in_dividend, in_divisor, out_ready, div_quotient, div_valid, div_busy,
    input  in_ready, out_valid, out_quotient, out_dz, err_timeout, div_dividend, div_divisor
  );
endinterface

// File: rtl/qdiv_sequencer.sv
// Job sequencer for the Q15.16 sign-magnitude iterative divider: queues jobs, issues them
// one at a time, answers divide-by-zero and repeated jobs locally, and bounds divider hangs.
module qdiv_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter logic [31:0] SAT_POS = 32'h7FFF_FFFF,
  parameter logic [31:0] SAT_NEG = 32'hFFFF_FFFF
) (
  input logic             clk,
  input logic             rst,
  qdiv_sequencer_if.slave bus
);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned TW  = $clog2(TIMEOUT);
  localparam logic [31:0] ONE = 32'h0001_0000;

  typedef struct packed {
    logic [31:0] dividend;
    logic [31:0] divisor;
  } job_t;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESULT} state_t;

  state_t        state;
  job_t          fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  job_t          head;
  job_t          job_q;
  job_t          div_job;
  logic [TW-1:0] timer;
  logic          timer_done;
  logic          cache_valid;
  logic [31:0]   cache_quotient;
  logic          push;
  logic          pop;

  function automatic logic [31:0] sat_val(input logic sign_a, input logic sign_b);
    return (sign_a == sign_b) ? SAT_POS : SAT_NEG;
  endfunction

  assign push       = bus.in_valid && bus.in_ready;
  assign pop        = (state == IDLE) && (count != '0) && !bus.out_valid;
  assign head       = fifo_mem[rd_ptr];
  // The cache key is always the operand pair currently held on the divider inputs.
  assign div_job    = {bus.div_dividend, bus.div_divisor};
  assign timer_done = (timer == TW'(TIMEOUT - 1));

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (pop && !push) begin
      count_next = count - CW'(1);
    end
  end

  // Job storage; contents are meaningless outside the valid window so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{dividend: bus.in_dividend, divisor: bus.in_divisor};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      bus.in_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count        <= count_next;
      bus.in_ready <= (count_next != CW'(DEPTH));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      job_q            <= '0;
      timer            <= '0;
      cache_valid      <= 1'b1;
      cache_quotient   <= '0;
      bus.div_dividend <= '0;
      bus.div_divisor  <= ONE;
      bus.out_valid    <= 1'b0;
      bus.out_quotient <= '0;
      bus.out_dz       <= 1'b0;
      bus.err_timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            if (head.divisor[30:0] == 31'd0) begin
              bus.out_quotient <= sat_val(head.dividend[31], head.divisor[31]);
              bus.out_dz       <= 1'b1;
              state            <= RESULT;
            end else if (cache_valid && (head == div_job)) begin
              bus.out_quotient <= cache_quotient;
              bus.out_dz       <= 1'b0;
              state            <= RESULT;
            end else begin
              job_q <= head;
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          bus.div_dividend <= job_q.dividend;
          bus.div_divisor  <= job_q.divisor;
          timer            <= '0;
          cache_valid      <= 1'b0;
          state            <= WAIT_BUSY;
        end
        // div_valid is only trusted once the divider has shown busy for this job.
        WAIT_BUSY, WAIT_DONE: begin
          timer <= timer + TW'(1);
          if ((state == WAIT_DONE) && bus.div_valid) begin
            bus.out_quotient <= bus.div_quotient;
            bus.out_dz       <= 1'b0;
            cache_quotient   <= bus.div_quotient;
            cache_valid      <= 1'b1;
            state            <= RESULT;
          end else if (timer_done) begin
            bus.out_quotient <= sat_val(bus.div_dividend[31], bus.div_divisor[31]);
            bus.out_dz       <= 1'b0;
            bus.err_timeout  <= 1'b1;
            cache_valid      <= 1'b0;
            state            <= RESULT;
          end else if ((state == WAIT_BUSY) && bus.div_busy) begin
            state <= WAIT_DONE;
          end
        end
        RESULT: begin
          if (!bus.out_valid) begin
            bus.out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
